// File: rtl/sprite_row_fetcher_if.sv
// Sprite ROM read port: address out from the fetcher, 2-bit palette data back
// one cycle later.
interface sprite_row_fetcher_if;
   logic [15:0] rom_address;
   logic [1:0]  rom_data;

   modport master (output rom_address, input rom_data);
   modport slave  (input rom_address, output rom_data);
endinterface

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from ROM per scanline into a local buffer, then serves
// per-pixel palette indices during active video.
module sprite_row_fetcher #(
   parameter int SPR_W    = 60,
   parameter int SPR_H    = 100,
   parameter int N_FRAMES = 6
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       line_start,
   input  logic [9:0]                 line_y,
   input  logic [9:0]                 sprite_x,
   input  logic [9:0]                 sprite_y,
   input  logic [2:0]                 frame_sel,
   input  logic                       flip_x,
   input  logic [9:0]                 DrawX,
   sprite_row_fetcher_if.master       rom,
   output logic                       busy,
   output logic [1:0]                 pixel_idx,
   output logic                       pixel_valid
);

   localparam int CW = $clog2(SPR_W);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [CW-1:0]   cap_col;
   logic            cap_vld;
   logic            row_hit;
   logic            flip_q;
   logic [9:0]      sx_q;
   logic [1:0]      row_buf [SPR_W];

   // Row decode on 11 bits so sprite_y+SPR_H-1 cannot wrap past 1023.
   logic            hit;
   logic [15:0]     base_nxt;
   assign hit = ({1'b0, line_y} >= {1'b0, sprite_y}) &&
                ({1'b0, line_y} <= {1'b0, sprite_y} + 11'(SPR_H - 1)) &&
                (32'(frame_sel) < N_FRAMES);
   assign base_nxt = 16'(frame_sel) * 16'(SPR_W * SPR_H) +
                     16'(line_y - sprite_y) * 16'(SPR_W);

   logic [10:0]     dx;
   logic            in_span;
   logic [1:0]      pix;
   assign dx      = {1'b0, DrawX} - {1'b0, sx_q};
   assign in_span = ({1'b0, DrawX} >= {1'b0, sx_q}) &&
                    ({1'b0, DrawX} <= {1'b0, sx_q} + 11'(SPR_W - 1));
   assign pix     = row_buf[dx[CW-1:0]];

   // Buffer needs no reset: row_hit masks stale contents.
   always_ff @(posedge Clk) begin
      if (!Reset && cap_vld) begin
         if (flip_q) row_buf[CW'(SPR_W - 1) - cap_col] <= rom.rom_data;
         else        row_buf[cap_col]                 <= rom.rom_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state           <= IDLE;
         rom.rom_address <= '0;
         busy            <= 1'b0;
         pixel_idx       <= '0;
         pixel_valid     <= 1'b0;
         row_hit         <= 1'b0;
         col             <= '0;
         cap_col         <= '0;
         cap_vld         <= 1'b0;
         flip_q          <= 1'b0;
         sx_q            <= '0;
      end else begin
         // ROM data lags the address by one cycle; an abort drops the in-flight datum.
         cap_vld     <= (state == FETCH) && !line_start;
         cap_col     <= col;
         pixel_idx   <= '0;
         pixel_valid <= 1'b0;
         if (line_start) begin
            sx_q    <= sprite_x;
            flip_q  <= flip_x;
            row_hit <= hit;
            col     <= '0;
            if (hit) begin
               state           <= FETCH;
               busy            <= 1'b1;
               rom.rom_address <= base_nxt;
            end else begin
               state           <= READY;
               busy            <= 1'b0;
               rom.rom_address <= '0;
            end
         end else begin
            case (state)
               FETCH: begin
                  if (col == CW'(SPR_W - 1)) begin
                     state           <= DRAIN;
                     rom.rom_address <= '0;
                  end else begin
                     col             <= col + 1'b1;
                     rom.rom_address <= rom.rom_address + 16'd1;
                  end
               end
               DRAIN: begin
                  state <= READY;
                  busy  <= 1'b0;
               end
               READY: begin
                  if (row_hit && in_span) begin
                     pixel_idx   <= pix;
                     pixel_valid <= |pix;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a 1-cycle-latency ROM model.
module tb_sprite_row_fetcher;
   logic       Clk = 1'b0;
   logic       Reset;
   logic       line_start;
   logic [9:0] line_y, sprite_x, sprite_y, DrawX;
   logic [2:0] frame_sel;
   logic       flip_x;
   logic       busy;
   logic [1:0] pixel_idx;
   logic       pixel_valid;
   int         checks = 0;
   int         errors = 0;

   sprite_row_fetcher_if rif ();

   sprite_row_fetcher dut (
      .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_sel(frame_sel),
      .flip_x(flip_x), .DrawX(DrawX), .rom(rif.master), .busy(busy),
      .pixel_idx(pixel_idx), .pixel_valid(pixel_valid)
   );

   always #5 Clk = ~Clk;

   // ROM contents: column 5 of every row transparent, other entries 1..3 varying by row and column.
   function automatic logic [1:0] rom_fn(input logic [15:0] a);
      int v;
      v = int'(a);
      if (v % 60 == 5) return 2'd0;
      return 2'((v + v / 60) % 3 + 1);
   endfunction

   always @(posedge Clk) rif.rom_data <= rom_fn(rif.rom_address);

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Pulses line_start for one cycle; returns in cycle T+1.
   task automatic start_line(input logic [9:0] ly, input logic [9:0] sy, input logic [9:0] sx,
                             input logic [2:0] fs, input logic fl);
      line_y = ly; sprite_y = sy; sprite_x = sx; frame_sel = fs; flip_x = fl;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; line_start = 1'b0; DrawX = '0;
      line_y = '0; sprite_x = '0; sprite_y = '0; frame_sel = '0; flip_x = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || rif.rom_address !== 16'd0 || pixel_valid !== 1'b0 || pixel_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b addr=%0d pv=%b idx=%0d, want 0/0/0/0", busy, rif.rom_address, pixel_valid, pixel_idx);
      end
      start_line(10'd60, 10'd50, 10'd100, 3'd2, 1'b0);
      repeat (9) tick();
      Reset = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || rif.rom_address !== 16'd0 || pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fetch: busy=%b addr=%0d pv=%b, want 0/0/0", busy, rif.rom_address, pixel_valid);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || rif.rom_address !== 16'd0) begin
         errors++;
         $display("FAIL reset_idle_hold: busy=%b addr=%0d, want 0/0", busy, rif.rom_address);
      end
   endtask

   task automatic test_fetch();
      start_line(10'd60, 10'd50, 10'd100, 3'd2, 1'b0);
      checks++;
      if (rif.rom_address !== 16'd12600 || busy !== 1'b1) begin
         errors++;
         $display("FAIL fetch_first_addr: addr=%0d busy=%b, want 12600/1", rif.rom_address, busy);
      end
      repeat (59) tick();
      checks++;
      if (rif.rom_address !== 16'd12659) begin
         errors++;
         $display("FAIL fetch_last_addr: addr=%0d, want 12659", rif.rom_address);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || rif.rom_address !== 16'd0) begin
         errors++;
         $display("FAIL fetch_drain: busy=%b addr=%0d, want 1/0", busy, rif.rom_address);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL fetch_ready: busy=%b, want 0", busy);
      end
      DrawX = 10'd100; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12600) || pixel_valid !== 1'b1) begin
         errors++;
         $display("FAIL pix_left: idx=%0d pv=%b, want %0d/1", pixel_idx, pixel_valid, rom_fn(16'd12600));
      end
      DrawX = 10'd159; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12659) || pixel_valid !== 1'b1) begin
         errors++;
         $display("FAIL pix_right: idx=%0d pv=%b, want %0d/1", pixel_idx, pixel_valid, rom_fn(16'd12659));
      end
      DrawX = 10'd160; tick();
      checks++;
      if (pixel_idx !== 2'd0 || pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL pix_past_right: idx=%0d pv=%b, want 0/0", pixel_idx, pixel_valid);
      end
      DrawX = 10'd99; tick();
      checks++;
      if (pixel_idx !== 2'd0 || pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL pix_before_left: idx=%0d pv=%b, want 0/0", pixel_idx, pixel_valid);
      end
   endtask

   task automatic test_transparent();
      DrawX = 10'd105; tick();
      checks++;
      if (pixel_idx !== 2'd0 || pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL transp_col5: idx=%0d pv=%b, want 0/0", pixel_idx, pixel_valid);
      end
      DrawX = 10'd104; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12604) || pixel_valid !== 1'b1) begin
         errors++;
         $display("FAIL transp_col4: idx=%0d pv=%b, want %0d/1", pixel_idx, pixel_valid, rom_fn(16'd12604));
      end
      DrawX = 10'd106; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12606) || pixel_valid !== 1'b1) begin
         errors++;
         $display("FAIL transp_col6: idx=%0d pv=%b, want %0d/1", pixel_idx, pixel_valid, rom_fn(16'd12606));
      end
   endtask

   task automatic test_flip();
      start_line(10'd60, 10'd50, 10'd100, 3'd2, 1'b1);
      repeat (61) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flip_ready: busy=%b, want 0", busy);
      end
      DrawX = 10'd100; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12659)) begin
         errors++;
         $display("FAIL flip_left: idx=%0d, want %0d", pixel_idx, rom_fn(16'd12659));
      end
      DrawX = 10'd159; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12600)) begin
         errors++;
         $display("FAIL flip_right: idx=%0d, want %0d", pixel_idx, rom_fn(16'd12600));
      end
   endtask

   task automatic test_miss();
      logic [9:0] ly [3];
      logic [2:0] fs [3];
      ly[0] = 10'd49;  fs[0] = 3'd2;
      ly[1] = 10'd150; fs[1] = 3'd2;
      ly[2] = 10'd60;  fs[2] = 3'd6;
      for (int i = 0; i < 3; i++) begin
         start_line(ly[i], 10'd50, 10'd100, fs[i], 1'b0);
         checks++;
         if (rif.rom_address !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL miss%0d_ready: addr=%0d busy=%b, want 0/0", i, rif.rom_address, busy);
         end
         for (int x = 100; x < 160; x += 29) begin
            DrawX = 10'(x); tick();
            checks++;
            if (pixel_valid !== 1'b0 || pixel_idx !== 2'd0) begin
               errors++;
               $display("FAIL miss%0d_pix x=%0d: idx=%0d pv=%b, want 0/0", i, x, pixel_idx, pixel_valid);
            end
         end
      end
      // Bottom row of the sprite is still a hit.
      start_line(10'd149, 10'd50, 10'd100, 3'd2, 1'b0);
      checks++;
      if (rif.rom_address !== 16'd17940 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bottom_row_addr: addr=%0d busy=%b, want 17940/1", rif.rom_address, busy);
      end
      repeat (61) tick();
   endtask

   task automatic test_back_to_back();
      start_line(10'd60, 10'd50, 10'd100, 3'd2, 1'b0);
      repeat (19) tick();
      start_line(10'd61, 10'd50, 10'd100, 3'd2, 1'b0);
      checks++;
      if (rif.rom_address !== 16'd12660 || busy !== 1'b1 || pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_restart: addr=%0d busy=%b pv=%b, want 12660/1/0", rif.rom_address, busy, pixel_valid);
      end
      repeat (60) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_t81: busy=%b, want 1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready_t82: busy=%b, want 0", busy);
      end
      DrawX = 10'd100; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12660)) begin
         errors++;
         $display("FAIL abort_col0: idx=%0d, want %0d", pixel_idx, rom_fn(16'd12660));
      end
      DrawX = 10'd130; tick();
      checks++;
      if (pixel_idx !== rom_fn(16'd12690)) begin
         errors++;
         $display("FAIL abort_col30: idx=%0d, want %0d", pixel_idx, rom_fn(16'd12690));
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_transparent();
      test_flip();
      test_miss();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
